// File: rtl/or_gate_checker.sv
// Response monitor for bitwise gate blocks: counts vectors and mismatches per run.
// Optional first-failure capture is built when OR_GATE_CHECKER_LOG_EN is defined.
module or_gate_checker #(
  parameter int WIDTH = 4,
  parameter int OP    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [15:0]      num_vec,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      vec_cnt,
  output logic [15:0]      err_cnt,
  output logic [15:0]      first_err_idx,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic [WIDTH-1:0] first_err_c
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, next_state;
  logic [15:0]      num_vec_q;
  logic [15:0]      vec_next, err_next;
  logic [WIDTH-1:0] expected;
  logic             accept, mismatch, last;

  always_comb begin
    case (OP)
      1:       expected = in_a & in_b;
      2:       expected = in_a ^ in_b;
      3:       expected = ~(in_a | in_b);
      default: expected = in_a | in_b;
    endcase
  end

  // start outranks a coincident vector, so acceptance excludes it
  assign accept   = (state == RUN) && in_valid && !start;
  assign mismatch = accept && (in_c != expected);
  assign last     = accept && ((vec_cnt + 16'd1) == num_vec_q);

  always_comb begin
    next_state = state;
    vec_next   = vec_cnt;
    err_next   = err_cnt;
    if (start) begin
      next_state = (num_vec == 16'd0) ? DONE : RUN;
      vec_next   = 16'd0;
      err_next   = 16'd0;
    end else begin
      if (accept) begin
        vec_next = vec_cnt + 16'd1;
        if (mismatch && (err_cnt != 16'hFFFF))
          err_next = err_cnt + 16'd1;
      end
      if (last)
        next_state = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      vec_cnt   <= 16'd0;
      err_cnt   <= 16'd0;
      num_vec_q <= 16'd0;
    end else begin
      state   <= next_state;
      busy    <= (next_state == RUN);
      done    <= (next_state == DONE);
      pass    <= (next_state == DONE) && (err_next == 16'd0);
      vec_cnt <= vec_next;
      err_cnt <= err_next;
      if (start)
        num_vec_q <= num_vec;
    end
  end

`ifdef OR_GATE_CHECKER_LOG_EN
  logic first_capture;

  // err_cnt never wraps, so zero means no mismatch has been seen yet this run
  assign first_capture = mismatch && (err_cnt == 16'd0);

  always_ff @(posedge clk) begin
    if (rst || start) begin
      first_err_idx <= 16'd0;
      first_err_a   <= '0;
      first_err_b   <= '0;
      first_err_c   <= '0;
    end else if (first_capture) begin
      first_err_idx <= vec_cnt;
      first_err_a   <= in_a;
      first_err_b   <= in_b;
      first_err_c   <= in_c;
    end
  end
`else
  assign first_err_idx = 16'd0;
  assign first_err_a   = '0;
  assign first_err_b   = '0;
  assign first_err_c   = '0;
`endif

endmodule

// File: tb/tb_or_gate_checker.sv
// Directed bench for or_gate_checker: OR instance for most scenarios, AND instance for saturation.
module tb_or_gate_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // OR instance
  logic        start0 = 0, valid0 = 0;
  logic [15:0] num0 = 0;
  logic [3:0]  a0 = 0, b0 = 0, c0 = 0;
  logic        busy0, done0, pass0;
  logic [15:0] vcnt0, ecnt0, fidx0;
  logic [3:0]  fa0, fb0, fc0;

  // AND instance
  logic        start1 = 0, valid1 = 0;
  logic [15:0] num1 = 0;
  logic [3:0]  a1 = 0, b1 = 0, c1 = 0;
  logic        busy1, done1, pass1;
  logic [15:0] vcnt1, ecnt1, fidx1;
  logic [3:0]  fa1, fb1, fc1;

  or_gate_checker #(.WIDTH(4), .OP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .num_vec(num0), .in_valid(valid0),
    .in_a(a0), .in_b(b0), .in_c(c0), .busy(busy0), .done(done0), .pass(pass0),
    .vec_cnt(vcnt0), .err_cnt(ecnt0), .first_err_idx(fidx0),
    .first_err_a(fa0), .first_err_b(fb0), .first_err_c(fc0));

  or_gate_checker #(.WIDTH(4), .OP(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .num_vec(num1), .in_valid(valid1),
    .in_a(a1), .in_b(b1), .in_c(c1), .busy(busy1), .done(done1), .pass(pass1),
    .vec_cnt(vcnt1), .err_cnt(ecnt1), .first_err_idx(fidx1),
    .first_err_a(fa1), .first_err_b(fb1), .first_err_c(fc1));

`ifdef OR_GATE_CHECKER_LOG_EN
  localparam bit LOG = 1'b1;
`else
  localparam bit LOG = 1'b0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    n_vec++; if ({busy0, done0, pass0} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b expected 000", {busy0, done0, pass0}); end
    n_vec++; if ({vcnt0, ecnt0, fidx0} !== 48'd0) begin n_err++; $display("FAIL reset_counts: got %h expected 0", {vcnt0, ecnt0, fidx0}); end
    n_vec++; if ({fa0, fb0, fc0} !== 12'd0) begin n_err++; $display("FAIL reset_first: got %h expected 0", {fa0, fb0, fc0}); end
    n_vec++; if ({busy1, done1, pass1, vcnt1, ecnt1} !== 35'd0) begin n_err++; $display("FAIL reset_dut1: got %h expected 0", {busy1, done1, pass1, vcnt1, ecnt1}); end
  endtask

  task automatic test_or_exhaustive(input bit fault);
    logic [7:0]  idx;
    int          early_done;
    early_done = 0;
    num0 = 16'd256; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    n_vec++; if (busy0 !== 1'b1 || done0 !== 1'b0 || vcnt0 !== 16'd0 || ecnt0 !== 16'd0) begin
      n_err++; $display("FAIL exh_start: busy=%b done=%b vec=%0d err=%0d expected 1 0 0 0", busy0, done0, vcnt0, ecnt0); end
    for (int i = 0; i < 256; i++) begin
      idx = i[7:0];
      a0 = idx[7:4]; b0 = idx[3:0]; c0 = idx[7:4] | idx[3:0];
      if (fault && i == 5) c0 = 4'h4;
      valid0 = 1'b1;
      tick();
      if (i < 255 && done0 !== 1'b0) early_done++;
    end
    valid0 = 1'b0;
    n_vec++; if (early_done != 0) begin n_err++; $display("FAIL exh_early_done: got %0d early cycles expected 0", early_done); end
    n_vec++; if (done0 !== 1'b1 || busy0 !== 1'b0) begin n_err++; $display("FAIL exh_done: done=%b busy=%b expected 1 0", done0, busy0); end
    n_vec++; if (vcnt0 !== 16'd256) begin n_err++; $display("FAIL exh_vec_cnt: got %0d expected 256", vcnt0); end
    n_vec++; if (ecnt0 !== (fault ? 16'd1 : 16'd0)) begin n_err++; $display("FAIL exh_err_cnt: got %0d expected %0d", ecnt0, fault); end
    n_vec++; if (pass0 !== !fault) begin n_err++; $display("FAIL exh_pass: got %b expected %b", pass0, !fault); end
    if (fault) begin
      n_vec++; if (fidx0 !== (LOG ? 16'd5 : 16'd0)) begin n_err++; $display("FAIL exh_first_idx: got %0d expected %0d", fidx0, LOG ? 5 : 0); end
      n_vec++; if ({fa0, fb0, fc0} !== (LOG ? 12'h054 : 12'h000)) begin n_err++; $display("FAIL exh_first_abc: got %h expected %h", {fa0, fb0, fc0}, LOG ? 12'h054 : 12'h000); end
    end
    tick();
    n_vec++; if (done0 !== 1'b1) begin n_err++; $display("FAIL exh_done_held: got %b expected 1", done0); end
  endtask

  task automatic test_gapped();
    rst = 1'b1; tick(); rst = 1'b0;
    a0 = 4'h3; b0 = 4'h8; c0 = 4'h0; valid0 = 1'b1;
    tick(); tick();
    valid0 = 1'b0;
    n_vec++; if (vcnt0 !== 16'd0 || ecnt0 !== 16'd0 || busy0 !== 1'b0) begin
      n_err++; $display("FAIL idle_ignore: vec=%0d err=%0d busy=%b expected 0 0 0", vcnt0, ecnt0, busy0); end
    num0 = 16'd4; start0 = 1'b1; tick(); start0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a0 = k[3:0]; b0 = 4'hA; c0 = k[3:0] | 4'hA; valid0 = 1'b1;
      tick();
      valid0 = 1'b0;
      if (k < 3) begin
        n_vec++; if (busy0 !== 1'b1 || done0 !== 1'b0 || vcnt0 !== 16'(k + 1)) begin
          n_err++; $display("FAIL gap_mid%0d: busy=%b done=%b vec=%0d expected 1 0 %0d", k, busy0, done0, vcnt0, k + 1); end
        tick();
      end
    end
    n_vec++; if (busy0 !== 1'b0 || done0 !== 1'b1 || pass0 !== 1'b1 || vcnt0 !== 16'd4) begin
      n_err++; $display("FAIL gap_end: busy=%b done=%b pass=%b vec=%0d expected 0 1 1 4", busy0, done0, pass0, vcnt0); end
    valid0 = 1'b1; c0 = 4'h0; tick(); valid0 = 1'b0;
    n_vec++; if (vcnt0 !== 16'd4 || ecnt0 !== 16'd0) begin n_err++; $display("FAIL done_ignore: vec=%0d err=%0d expected 4 0", vcnt0, ecnt0); end
  endtask

  task automatic test_abort();
    num0 = 16'd4; start0 = 1'b1; tick(); start0 = 1'b0;
    a0 = 4'h1; b0 = 4'h2; c0 = 4'h0; valid0 = 1'b1; tick();
    c0 = 4'h3; tick();
    valid0 = 1'b0;
    n_vec++; if (vcnt0 !== 16'd2 || ecnt0 !== 16'd1) begin n_err++; $display("FAIL abort_pre: vec=%0d err=%0d expected 2 1", vcnt0, ecnt0); end
    start0 = 1'b1; valid0 = 1'b1; c0 = 4'hF; tick(); start0 = 1'b0; valid0 = 1'b0;
    n_vec++; if (vcnt0 !== 16'd0 || ecnt0 !== 16'd0 || busy0 !== 1'b1 || done0 !== 1'b0) begin
      n_err++; $display("FAIL abort_restart: vec=%0d err=%0d busy=%b done=%b expected 0 0 1 0", vcnt0, ecnt0, busy0, done0); end
    n_vec++; if ({fidx0, fa0, fb0, fc0} !== 28'd0) begin n_err++; $display("FAIL abort_first_clr: got %h expected 0", {fidx0, fa0, fb0, fc0}); end
    for (int k = 0; k < 4; k++) begin
      a0 = 4'h5; b0 = k[3:0]; c0 = 4'h5 | k[3:0]; valid0 = 1'b1; tick();
    end
    valid0 = 1'b0;
    n_vec++; if (done0 !== 1'b1 || pass0 !== 1'b1 || vcnt0 !== 16'd4) begin
      n_err++; $display("FAIL abort_rerun: done=%b pass=%b vec=%0d expected 1 1 4", done0, pass0, vcnt0); end
    num0 = 16'd0; start0 = 1'b1; tick(); start0 = 1'b0;
    n_vec++; if (done0 !== 1'b1 || pass0 !== 1'b1 || busy0 !== 1'b0 || vcnt0 !== 16'd0) begin
      n_err++; $display("FAIL zero_len: done=%b pass=%b busy=%b vec=%0d expected 1 1 0 0", done0, pass0, busy0, vcnt0); end
  endtask

  task automatic test_reset_mid_run();
    num0 = 16'd4; start0 = 1'b1; tick(); start0 = 1'b0;
    a0 = 4'h9; b0 = 4'h6; valid0 = 1'b1;
    c0 = 4'hF; tick();
    c0 = 4'h9; tick();
    c0 = 4'hF; tick();
    valid0 = 1'b0;
    n_vec++; if (vcnt0 !== 16'd3 || ecnt0 !== 16'd1) begin n_err++; $display("FAIL rst_pre: vec=%0d err=%0d expected 3 1", vcnt0, ecnt0); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_vec++; if ({busy0, done0, pass0, vcnt0, ecnt0, fidx0, fa0, fb0, fc0} !== 63'd0) begin
      n_err++; $display("FAIL rst_mid: got %h expected 0", {busy0, done0, pass0, vcnt0, ecnt0, fidx0, fa0, fb0, fc0}); end
    num0 = 16'd4; start0 = 1'b1; tick(); start0 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      a0 = k[3:0]; b0 = 4'h0; c0 = k[3:0]; valid0 = 1'b1; tick();
    end
    valid0 = 1'b0;
    n_vec++; if (done0 !== 1'b1 || pass0 !== 1'b1 || ecnt0 !== 16'd0) begin
      n_err++; $display("FAIL rst_rerun: done=%b pass=%b err=%0d expected 1 1 0", done0, pass0, ecnt0); end
  endtask

  task automatic test_saturation();
    logic [7:0] idx;
    num1 = 16'hFFFF; start1 = 1'b1; tick(); start1 = 1'b0;
    for (int i = 0; i < 65535; i++) begin
      idx = i[7:0];
      a1 = idx[7:4]; b1 = idx[3:0]; c1 = ~(idx[7:4] & idx[3:0]);
      valid1 = 1'b1;
      tick();
      if (i == 99) begin
        n_vec++; if (ecnt1 !== 16'd100 || vcnt1 !== 16'd100) begin n_err++; $display("FAIL sat_mid: vec=%0d err=%0d expected 100 100", vcnt1, ecnt1); end
      end
    end
    valid1 = 1'b0;
    n_vec++; if (ecnt1 !== 16'hFFFF || vcnt1 !== 16'hFFFF) begin n_err++; $display("FAIL sat_end: vec=%h err=%h expected ffff ffff", vcnt1, ecnt1); end
    n_vec++; if (done1 !== 1'b1 || pass1 !== 1'b0 || busy1 !== 1'b0) begin
      n_err++; $display("FAIL sat_flags: done=%b pass=%b busy=%b expected 1 0 0", done1, pass1, busy1); end
    n_vec++; if ({fidx1, fa1, fb1, fc1} !== (LOG ? 28'h000000F : 28'd0)) begin
      n_err++; $display("FAIL sat_first: got %h expected %h", {fidx1, fa1, fb1, fc1}, LOG ? 28'h000000F : 28'd0); end
  endtask

  initial begin
    test_reset();
    test_or_exhaustive(1'b0);
    test_or_exhaustive(1'b1);
    test_gapped();
    test_abort();
    test_reset_mid_run();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
